mul_div_ex: RTL

Iterative multiply/divide unit in the EX stage. Consumes the ALU second-operand mux output (rt data or sign-extended immediate) as operand B and rs data as operand A. Executes MULT/MULTU/DIV/DIVU over a fixed number of cycles into architectural HI/LO registers. Raises busy so hazard logic can stall IF/ID/EX while an operation is in flight.

---
 rtl/mul_div_ex.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mul_div_ex.sv
// Iterative multiply/divide unit for the EX stage.
// MULT/MULTU use shift-add and DIV/DIVU use restoring shift-subtract. Both run on
// operand magnitudes, with a sign fix-up before HI/LO are written. Every operation
// keeps busy high for DATA_W+1 cycles and then pulses done for one cycle.
module mul_div_ex #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              div0,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic              is_div_q;
  logic              neg_res_q;   // product / quotient must be negated
  logic              neg_rem_q;   // remainder takes the dividend's sign
  logic              zero_div_q;  // divide with zero divisor
  logic [DATA_W-1:0] a_raw_q;     // original dividend, returned in HI on divide-by-zero
  logic [DATA_W-1:0] b_mag_q;
  // Mult: acc_hi = partial product high half, acc_lo = multiplier shifting out.
  // Div:  acc_hi = partial remainder, acc_lo = dividend shifting out / quotient in.
  logic [DATA_W-1:0] acc_hi_q;
  logic [DATA_W-1:0] acc_lo_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              done_q, div0_q;

  // Operand conditioning at the accept edge
  logic              op_signed, a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;

  // One iteration step
  logic [DATA_W:0]   mult_sum;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_diff;
  logic [DATA_W-1:0] step_hi, step_lo;

  // Sign fix-up and final HI/LO values
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   rem_mag, quo_fix, rem_fix;
  logic [DATA_W-1:0]   fix_hi, fix_lo;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CntLast) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand magnitudes and result signs; op[0]=0 selects the signed variants
  always_comb begin
    op_signed = ~op[0];
    a_neg     = op_signed & opA[DATA_W-1];
    b_neg     = op_signed & opB[DATA_W-1];
    a_mag     = a_neg ? -opA : opA;
    b_mag     = b_neg ? -opB : opB;
  end

  // Single shift-add or restoring shift-subtract step
  always_comb begin
    mult_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_mag_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    step_hi   = '0;
    step_lo   = '0;
    if (is_div_q) begin
      // A clear borrow bit means the shifted remainder was >= divisor
      if (!div_diff[DATA_W]) begin
        step_hi = div_diff[DATA_W-1:0];
        step_lo = {acc_lo_q[DATA_W-2:0], 1'b1};
      end else begin
        step_hi = div_shift[DATA_W-1:0];
        step_lo = {acc_lo_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      step_hi = mult_sum[DATA_W:1];
      step_lo = {mult_sum[0], acc_lo_q[DATA_W-1:1]};
    end
  end

  // Sign fix-up and selection of the values written to HI/LO
  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_res_q ? -prod : prod;
    rem_mag  = acc_hi_q;
    quo_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = neg_rem_q ? -rem_mag : rem_mag;
    fix_hi   = '0;
    fix_lo   = '0;
    if (zero_div_q) begin
      fix_hi = a_raw_q;
      fix_lo = '1;
    end else if (is_div_q) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end else begin
      fix_hi = prod_fix[2*DATA_W-1:DATA_W];
      fix_lo = prod_fix[DATA_W-1:0];
    end
  end

  // Datapath, HI/LO and completion flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      a_raw_q    <= '0;
      b_mag_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // An accepted start takes priority; a simultaneous MTHI/MTLO is dropped
            cnt_q      <= '0;
            is_div_q   <= op[1];
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= op[1] & a_neg;
            zero_div_q <= op[1] & (opB == '0);
            a_raw_q    <= opA;
            b_mag_q    <= b_mag;
            acc_hi_q   <= '0;
            acc_lo_q   <= a_mag;
          end else begin
            if (wr_hi) hi_q <= wr_data;
            if (wr_lo) lo_q <= wr_data;
          end
        end
        StRun: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        StFix: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          div0_q <= zero_div_q;
        end
        default: ;
      endcase
    end
  end

  // Output drive
  always_comb begin
    busy = (state_q != StIdle);
    done = done_q;
    div0 = div0_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule
